// File: rtl/morse_encoder.sv
// ---------------------------------------------------------------------------
// morse_encoder
//   Keys one ASCII character at a time as International Morse code.
//   Letters (either case) and digits are sent as dots and dashes. A space
//   becomes a seven-unit word gap. Any other code is rejected with a pulse.
//   Every output comes straight from a flop, so nothing glitches downstream.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   char_valid_i   a character is offered on char_in_i
//   char_in_i      ASCII code, sampled only on the accept edge
//   abort_i        cancels the character in flight (no effect while idle)
//   char_ready_o   high while idle; a character is accepted on this edge
//   morse_out_o    keyed signal, 1 = tone/LED on
//   busy_o         inverse of char_ready_o
//   letter_done_o  one-cycle pulse when a character and its trailing gap end
//   bad_char_o     one-cycle pulse when an unencodable code is rejected
// ---------------------------------------------------------------------------
module morse_encoder #(
  parameter int unsigned UNIT_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid_i,
  input  logic [7:0] char_in_i,
  input  logic       abort_i,
  output logic       char_ready_o,
  output logic       morse_out_o,
  output logic       busy_o,
  output logic       letter_done_o,
  output logic       bad_char_o
);

  typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

  localparam logic [31:0] UNIT_LAST = 32'(UNIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  units_q, units_d;
  logic [4:0]  pat_q, pat_d;
  logic [2:0]  elems_q, elems_d;
  logic        morse_q, morse_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bad_q, bad_d;

  logic [8:0]  code;
  logic        unitEnd;
  logic        phaseEnd;

  // Character table. Result is {encodable, element count, pattern}, where the
  // pattern is left-justified in reading order (bit 4 goes first, 1 = dash).
  // Lower case folds onto upper case before the lookup.
  function automatic logic [8:0] lookup(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
    case (u)
      "A": lookup = {1'b1, 3'd2, 5'b01000};
      "B": lookup = {1'b1, 3'd4, 5'b10000};
      "C": lookup = {1'b1, 3'd4, 5'b10100};
      "D": lookup = {1'b1, 3'd3, 5'b10000};
      "E": lookup = {1'b1, 3'd1, 5'b00000};
      "F": lookup = {1'b1, 3'd4, 5'b00100};
      "G": lookup = {1'b1, 3'd3, 5'b11000};
      "H": lookup = {1'b1, 3'd4, 5'b00000};
      "I": lookup = {1'b1, 3'd2, 5'b00000};
      "J": lookup = {1'b1, 3'd4, 5'b01110};
      "K": lookup = {1'b1, 3'd3, 5'b10100};
      "L": lookup = {1'b1, 3'd4, 5'b01000};
      "M": lookup = {1'b1, 3'd2, 5'b11000};
      "N": lookup = {1'b1, 3'd2, 5'b10000};
      "O": lookup = {1'b1, 3'd3, 5'b11100};
      "P": lookup = {1'b1, 3'd4, 5'b01100};
      "Q": lookup = {1'b1, 3'd4, 5'b11010};
      "R": lookup = {1'b1, 3'd3, 5'b01000};
      "S": lookup = {1'b1, 3'd3, 5'b00000};
      "T": lookup = {1'b1, 3'd1, 5'b10000};
      "U": lookup = {1'b1, 3'd3, 5'b00100};
      "V": lookup = {1'b1, 3'd4, 5'b00010};
      "W": lookup = {1'b1, 3'd3, 5'b01100};
      "X": lookup = {1'b1, 3'd4, 5'b10010};
      "Y": lookup = {1'b1, 3'd4, 5'b10110};
      "Z": lookup = {1'b1, 3'd4, 5'b11000};
      "0": lookup = {1'b1, 3'd5, 5'b11111};
      "1": lookup = {1'b1, 3'd5, 5'b01111};
      "2": lookup = {1'b1, 3'd5, 5'b00111};
      "3": lookup = {1'b1, 3'd5, 5'b00011};
      "4": lookup = {1'b1, 3'd5, 5'b00001};
      "5": lookup = {1'b1, 3'd5, 5'b00000};
      "6": lookup = {1'b1, 3'd5, 5'b10000};
      "7": lookup = {1'b1, 3'd5, 5'b11000};
      "8": lookup = {1'b1, 3'd5, 5'b11100};
      "9": lookup = {1'b1, 3'd5, 5'b11110};
      default: lookup = 9'd0;
    endcase
  endfunction

  // Timing: cnt_q counts clocks inside one unit and units_q counts the whole
  // units still to go after the current one. Splitting the two keeps a 7x
  // gap exact without ever multiplying UNIT_CYCLES, so nothing can overflow.
  // Every state or element change lands on a unit boundary, which is where
  // cnt_q has just wrapped to zero, so the counter is reloaded there too.
  // Abort wins over everything except idle, where it is ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    units_d  = units_q;
    pat_d    = pat_q;
    elems_d  = elems_q;
    done_d   = 1'b0;
    bad_d    = 1'b0;
    code     = lookup(char_in_i);
    unitEnd  = (cnt_q == UNIT_LAST);
    phaseEnd = unitEnd && (units_q == 3'd0);

    if (state_q != IDLE) begin
      if (unitEnd) begin
        cnt_d = 32'd0;
        if (units_q != 3'd0) begin
          units_d = units_q - 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (char_valid_i) begin
          if (code[8]) begin
            state_d = MARK;
            pat_d   = code[4:0];
            elems_d = code[7:5];
            units_d = code[4] ? 3'd2 : 3'd0;
            cnt_d   = 32'd0;
          end else if (char_in_i == 8'h20) begin
            state_d = LGAP;
            units_d = 3'd6;
            cnt_d   = 32'd0;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      MARK: begin
        if (phaseEnd) begin
          if (elems_q > 3'd1) begin
            state_d = GAP;
            elems_d = elems_q - 3'd1;
            pat_d   = {pat_q[3:0], 1'b0};
            units_d = 3'd0;
          end else begin
            state_d = LGAP;
            elems_d = 3'd0;
            units_d = 3'd2;
          end
        end
      end
      GAP: begin
        if (phaseEnd) begin
          state_d = MARK;
          units_d = pat_q[4] ? 3'd2 : 3'd0;
        end
      end
      LGAP: begin
        if (phaseEnd) begin
          state_d = IDLE;
          pat_d   = 5'd0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && abort_i) begin
      state_d = IDLE;
      cnt_d   = 32'd0;
      units_d = 3'd0;
      pat_d   = 5'd0;
      elems_d = 3'd0;
      done_d  = 1'b0;
    end

    morse_d = (state_d == MARK);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output flops. Outputs are computed from the next state so they
  // line up with it, and the asynchronous reset drops the key at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      units_q <= 3'd0;
      pat_q   <= 5'd0;
      elems_q <= 3'd0;
      morse_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      pat_q   <= pat_d;
      elems_q <= elems_d;
      morse_q <= morse_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
    end
  end

  assign char_ready_o  = ready_q;
  assign morse_out_o   = morse_q;
  assign busy_o        = busy_q;
  assign letter_done_o = done_q;
  assign bad_char_o    = bad_q;

endmodule
